grant_scheduler16: RTL and testbench
====================================

GRANT_SCHEDULER16 -- requirements
Module: grant_scheduler16

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles a grant is held (used only when SCHED_TIMEOUT_EN is defined); legal range 2..255.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  16  request bit per requester; bit n = requester n.
REQ-005 SHALL have port done  input  1  current grantee releases the resource; sampled only in OWN.
REQ-006 SHALL have port gnt_valid  output  1  a grant is active.
REQ-007 SHALL have port gnt_idx  output  4  binary index of the granted requester.
REQ-008 SHALL have port gnt_onehot  output  16  one-hot grant; equals decode(gnt_idx) when gnt_valid=1, else all zero.
REQ-009 SHALL have port timeout_pulse  output  1  one-cycle pulse on forced release; present only when SCHED_TIMEOUT_EN is defined.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, OWN, RELEASE.
REQ-011 In IDLE with req != 0, SHALL latch a winner and enter OWN on the next edge; gnt_valid rises one cycle after req is first seen (latency 1).
REQ-012 In IDLE with req == 0, SHALL remain in IDLE; gnt_valid=0.
REQ-013 The winner SHALL be chosen round-robin: search starts at (last_gnt+1) mod 16 and proceeds upward with wrap 15->0; the first set req bit wins.
REQ-014 In OWN, gnt_valid, gnt_idx and gnt_onehot SHALL be held constant; changes on req, including deassertion by the grantee, SHALL be ignored.
REQ-015 In OWN with done=1, SHALL enter RELEASE on the next edge and store gnt_idx as last_gnt.
REQ-016 RELEASE SHALL last exactly one cycle with gnt_valid=0, then enter IDLE; there are no back-to-back grants without a gap cycle.
REQ-017 done asserted in IDLE or RELEASE SHALL be ignored.
REQ-018 After release, a grantee still requesting SHALL have the lowest priority in the next arbitration (fairness); if it is the only requester, it SHALL be granted again.
REQ-019 gnt_onehot SHALL be produced by the decoder sub-module from gnt_idx, gated by gnt_valid; the outputs are registered state, not combinational paths from req.

Reset
REQ-020 On rst=1, SHALL immediately and asynchronously enter IDLE with gnt_valid=0, gnt_idx=0, gnt_onehot=0, timeout_pulse=0, timeout counter=0, last_gnt=15, so the first search after reset begins at requester 0.
REQ-021 Reset asserted mid-grant SHALL drop the grant the same cycle; no RELEASE cycle occurs.

Configuration
REQ-022 Macro SCHED_TIMEOUT_EN: when defined, a counter SHALL run in OWN; if done has not been seen by the TIMEOUT-th OWN cycle, the block SHALL force RELEASE, update last_gnt, and pulse timeout_pulse for the single cycle coinciding with RELEASE.
REQ-023 If done=1 in that same last cycle, the release SHALL count as normal and timeout_pulse SHALL stay 0.
REQ-024 When SCHED_TIMEOUT_EN is undefined, there SHALL be no counter and no timeout_pulse port; a grant is held until done, indefinitely.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, OWN=2'd1, RELEASE=2'd2), the requester count constant (16) and the index width constant (4).
REQ-026 SHALL instantiate one sub-module, decoder4x16, for the index-to-one-hot conversion; the arbitration search SHALL stay in the top module.

Verification
REQ-027 Reset then req=16'h0001 -> gnt_valid=1, gnt_idx=0, gnt_onehot=16'h0001 one cycle later.
REQ-028 req=16'hFFFF held, done pulsed in each OWN cycle -> grants in the order 0,1,2,...,15,0, each separated by one RELEASE gap.
REQ-029 Grant to 5 active, req=16'h0021, done pulse -> next grant is 0 (wrap past 15), not 5.
REQ-030 Grantee 3 drops req in OWN without done -> gnt_idx stays 3 until done; done asserted in IDLE -> no effect.
REQ-031 rst asserted while grant 7 is held -> gnt_valid=0 and gnt_onehot=0 immediately; after reset, req=16'h8080 -> grant 7.
REQ-032 With SCHED_TIMEOUT_EN and TIMEOUT=4, grant with no done -> forced RELEASE after 4 OWN cycles with timeout_pulse=1 for one cycle; repeat with done in cycle 4 -> timeout_pulse stays 0.

Source files
------------

// File: rtl/grant_scheduler16_pkg.sv
// Shared constants and FSM state encoding for the 16-way grant scheduler.
package grant_scheduler16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/grant_scheduler16_decoder4x16.sv
// Index-to-one-hot decoder with an enable; the output is all zero while en_i is low.
module decoder4x16
  import grant_scheduler16_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign onehot_o[gi] = en_i && (idx_i == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/grant_scheduler16.sv
// Round-robin 16-requester grant scheduler: IDLE -> OWN -> RELEASE with a one-cycle gap.
// Define SCHED_TIMEOUT_EN to add a forced release after TIMEOUT OWN cycles and the timeout_pulse port.
module grant_scheduler16
  import grant_scheduler16_pkg::*;
#(
  parameter int TIMEOUT = 64
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot
`ifdef SCHED_TIMEOUT_EN
  ,
  output logic             timeout_pulse
`endif
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("grant_scheduler16: TIMEOUT must be in 2..255");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_gnt_q, last_gnt_d;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

`ifdef SCHED_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       tpulse_q, tpulse_d;
`endif

  // Search starts just above the last grantee, so it naturally ends with itself.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_gnt_q + IDX_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_gnt_d = last_gnt_q;
`ifdef SCHED_TIMEOUT_EN
    cnt_d      = '0;
    tpulse_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d   = ST_OWN;
          gnt_idx_d = win_idx;
        end
      end
      ST_OWN: begin
        if (done) begin
          state_d    = ST_RELEASE;
          last_gnt_d = gnt_idx_q;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d    = ST_RELEASE;
          last_gnt_d = gnt_idx_q;
          tpulse_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= '0;
      last_gnt_q <= IDX_W'(N_REQ - 1);
`ifdef SCHED_TIMEOUT_EN
      cnt_q      <= '0;
      tpulse_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_gnt_q <= last_gnt_d;
`ifdef SCHED_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tpulse_q   <= tpulse_d;
`endif
    end
  end

  assign gnt_valid = (state_q == ST_OWN);
  assign gnt_idx   = gnt_idx_q;
`ifdef SCHED_TIMEOUT_EN
  assign timeout_pulse = tpulse_q;
`endif

  decoder4x16 u_dec (
    .idx_i    (gnt_idx_q),
    .en_i     (gnt_valid),
    .onehot_o (gnt_onehot)
  );

endmodule

// File: tb/tb_grant_scheduler16.sv
// Directed bench for grant_scheduler16 with a cycle-level behavioural model and literal spot checks.
module tb_grant_scheduler16;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt_onehot;
`ifdef SCHED_TIMEOUT_EN
  logic        timeout_pulse;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  grant_scheduler16 #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
`ifdef SCHED_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner (-1 = none), a one-cycle release gap, and round-robin from the last owner.
  int m_owner, m_last, m_cnt;
  bit m_rel, m_tp;

  function automatic int pick(input logic [15:0] r, input int last);
    for (int k = 1; k <= 16; k++) begin
      if (r[(last + k) % 16]) return (last + k) % 16;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_rel <= 1'b0; m_last <= 15; m_cnt <= 0; m_tp <= 1'b0;
    end else begin
      m_tp <= 1'b0;
      if (m_owner >= 0) begin
        if (done) begin
          m_last <= m_owner; m_owner <= -1; m_rel <= 1'b1; m_cnt <= 0;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (m_cnt + 1 == TB_TIMEOUT) begin
          m_last <= m_owner; m_owner <= -1; m_rel <= 1'b1; m_cnt <= 0; m_tp <= 1'b1;
        end
`endif
        else m_cnt <= m_cnt + 1;
      end else if (m_rel) begin
        m_rel <= 1'b0;
      end else if (req != 16'h0) begin
        m_owner <= pick(req, m_last);
        m_cnt   <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      check("model_onehot", 32'(gnt_onehot), (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
      if (m_owner >= 0) check("model_idx", 32'(gnt_idx), 32'(m_owner));
`ifdef SCHED_TIMEOUT_EN
      check("model_tpulse", 32'(timeout_pulse), 32'(m_tp));
`endif
    end
  end

  task automatic wait_grant(output int idx);
    int n = 0;
    idx = -1;
    while (n < 20) begin
      @(negedge clk); #1;
      if (gnt_valid) begin
        idx = int'(gnt_idx);
        break;
      end
      n++;
    end
    if (idx < 0) check("wait_grant_valid", 32'(gnt_valid), 32'h1);
    else $display("grant idx=%0d req=%h at %0t", idx, req, $time);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk); #1;
    done = 1'b0;
  endtask

  initial begin
    int g;
    int order[$];
    int cnt;

    // Reset state and first grant
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_idx", 32'(gnt_idx), 32'h0);
    check("rst_onehot", 32'(gnt_onehot), 32'h0);
    req = 16'h0001;
    wait_grant(g);
    check("first_idx", 32'(g), 32'd0);
    check("first_onehot", 32'(gnt_onehot), 32'h0001);
    pulse_done();
    req = 16'h0000;

    // Full round-robin sweep from a fresh reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      wait_grant(g);
      order.push_back(g);
      pulse_done();
    end
    req = 16'h0000;
    for (int i = 0; i < 17; i++) check($sformatf("rr_order[%0d]", i), 32'(order[i]), 32'(i % 16));

    // Wrap past 15: grantee 5 yields to 0
    req = 16'h0020;
    wait_grant(g);
    check("grant5", 32'(g), 32'd5);
    req = 16'h0021;
    pulse_done();
    wait_grant(g);
    check("wrap_to0", 32'(g), 32'd0);
    req = 16'h0008;
    pulse_done();

    // Grantee 3 drops req; grant held until done; done in idle ignored
    wait_grant(g);
    check("grant3", 32'(g), 32'd3);
    req = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("hold3_valid", 32'(gnt_valid), 32'h1);
      check("hold3_idx", 32'(gnt_idx), 32'd3);
    end
    pulse_done();
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("idle_done_valid", 32'(gnt_valid), 32'h0);
    end
    done = 1'b0;

    // Fairness: lone requester regranted, otherwise it goes last
    req = 16'h0080;
    wait_grant(g);
    check("grant7", 32'(g), 32'd7);
    pulse_done();
    wait_grant(g);
    check("regrant7", 32'(g), 32'd7);
    req = 16'h8080;
    pulse_done();
    wait_grant(g);
    check("fair15", 32'(g), 32'd15);
    req = 16'h0080;
    pulse_done();
    wait_grant(g);
    check("grant7_again", 32'(g), 32'd7);

    // Asynchronous reset while grant 7 is held
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(gnt_valid), 32'h0);
    check("async_rst_onehot", 32'(gnt_onehot), 32'h0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    req = 16'h8080;
    wait_grant(g);
    check("post_rst_grant", 32'(g), 32'd7);
    check("post_rst_onehot", 32'(gnt_onehot), 32'h0080);
    req = 16'h0002;
    pulse_done();

`ifdef SCHED_TIMEOUT_EN
    // Forced release after TIMEOUT OWN cycles
    wait_grant(g);
    check("to_grant", 32'(g), 32'd1);
    cnt = 1;
    while (cnt < 20) begin
      @(negedge clk); #1;
      if (!gnt_valid) break;
      cnt++;
    end
    check("to_own_cycles", 32'(cnt), 32'(TB_TIMEOUT));
    check("to_pulse_hi", 32'(timeout_pulse), 32'h1);
    @(negedge clk); #1;
    check("to_pulse_lo", 32'(timeout_pulse), 32'h0);
    // done in the last OWN cycle counts as a normal release
    wait_grant(g);
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    #1 done = 1'b1;
    @(negedge clk); #1;
    done = 1'b0;
    check("to_done_valid", 32'(gnt_valid), 32'h0);
    check("to_done_pulse", 32'(timeout_pulse), 32'h0);
    req = 16'h0000;
`else
    // No timeout: grant held indefinitely without done
    wait_grant(g);
    check("hold_grant", 32'(g), 32'd1);
    repeat (80) @(negedge clk);
    #1;
    check("hold_long_valid", 32'(gnt_valid), 32'h1);
    check("hold_long_idx", 32'(gnt_idx), 32'd1);
    req = 16'h0000;
    pulse_done();
`endif
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
